strategy_switch: RTL and testbench

- Parametrised successor to the strategy output multiplexer.
- Selects one of N_STRAT strategy FSM output buses and drives it onto the sync-block output.
- Switches strategy only at a safe boundary: drain the running FSM, hold a safe output for a guard gap, then enable the new FSM.
- Sits between the strategy FSMs and the output drivers; the control register interface issues the select requests.

---
 rtl/strategy_switch.sv | 146 ++++++++++++++
 tb/tb_strategy_switch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/strategy_switch.sv
// Strategy output mux: switches the connected FSM only after drain + SAFE_VALUE guard gap.
// Latency: out is registered, 1 cycle from strat_out; a switch takes drain cycles + GAP_CYCLES + 1.
// Backpressure: none; requests are single-cycle strobes, the last in-range one before ACTIVE wins.
module strategy_switch #(
    parameter int               N_STRAT       = 5,
    parameter int               OUT_W         = 16,
    parameter int               SEL_W         = 8,
    parameter int               GAP_CYCLES    = 4,
    parameter int               DRAIN_TIMEOUT = 1024,
    parameter logic [OUT_W-1:0] SAFE_VALUE    = '0,
    parameter int               RESET_SEL     = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel_req,
    input  logic                     sel_valid,
    input  logic [N_STRAT*OUT_W-1:0] strat_out,
    input  logic [N_STRAT-1:0]       strat_busy,
    output logic [N_STRAT-1:0]       strat_en,
    output logic [OUT_W-1:0]         out,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     switching,
    output logic                     sel_err,
    output logic                     timeout_err
);

    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);

    typedef enum logic [1:0] {ACTIVE, DRAIN, GAP} state_t;

    function automatic logic [N_STRAT-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_STRAT-1:0] v;
        v = '0;
        for (int i = 0; i < N_STRAT; i++) begin
            if (idx == SEL_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    state_t             state, state_n;
    logic [SEL_W-1:0]   target, target_n, active_n;
    logic [N_STRAT-1:0] en_n;
    logic [OUT_W-1:0]   out_n, cur_slice;
    logic               sw_n, sel_err_n, timeout_n, cur_busy;
    logic [DW-1:0]      drain_cnt, drain_n;
    logic [GW-1:0]      gap_cnt, gap_n;
    logic               in_range, req_ok;
    logic [SEL_W-1:0]   next_target;

    assign in_range    = ({1'b0, sel_req} < (SEL_W+1)'(N_STRAT));
    assign req_ok      = sel_valid & in_range;
    assign next_target = req_ok ? sel_req : target;

    // Mux by compare so the index width never has to match N_STRAT.
    always_comb begin
        cur_slice = '0;
        cur_busy  = 1'b0;
        for (int i = 0; i < N_STRAT; i++) begin
            if (active_sel == SEL_W'(i)) begin
                cur_slice = strat_out[i*OUT_W +: OUT_W];
                cur_busy  = strat_busy[i];
            end
        end
    end

    always_comb begin
        state_n   = state;
        target_n  = target;
        active_n  = active_sel;
        en_n      = strat_en;
        out_n     = SAFE_VALUE;
        sw_n      = switching;
        drain_n   = drain_cnt;
        gap_n     = gap_cnt;
        sel_err_n = sel_valid & ~in_range;
        timeout_n = req_ok ? 1'b0 : timeout_err;
        case (state)
            ACTIVE: begin
                out_n = cur_slice;
                if (req_ok && sel_req != active_sel) begin
                    target_n = sel_req;
                    en_n     = '0;
                    sw_n     = 1'b1;
                    out_n    = SAFE_VALUE;
                    drain_n  = '0;
                    state_n  = DRAIN;
                end
            end
            DRAIN: begin
                en_n     = '0;
                target_n = next_target;
                if (!cur_busy) begin
                    state_n = GAP;
                    gap_n   = GW'(GAP_CYCLES - 1);
                end else if (drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
                    timeout_n = 1'b1;
                    state_n   = GAP;
                    gap_n     = GW'(GAP_CYCLES - 1);
                end else begin
                    drain_n = drain_cnt + DW'(1);
                end
            end
            GAP: begin
                target_n = next_target;
                if (gap_cnt == '0) begin
                    active_n = next_target;
                    en_n     = onehot(next_target);
                    sw_n     = 1'b0;
                    state_n  = ACTIVE;
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            default: state_n = ACTIVE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ACTIVE;
            target      <= RST_SEL;
            active_sel  <= RST_SEL;
            strat_en    <= onehot(RST_SEL);
            out         <= SAFE_VALUE;
            switching   <= 1'b0;
            sel_err     <= 1'b0;
            timeout_err <= 1'b0;
            drain_cnt   <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_n;
            target      <= target_n;
            active_sel  <= active_n;
            strat_en    <= en_n;
            out         <= out_n;
            switching   <= sw_n;
            sel_err     <= sel_err_n;
            timeout_err <= timeout_n;
            drain_cnt   <= drain_n;
            gap_cnt     <= gap_n;
        end
    end

endmodule

// File: tb/tb_strategy_switch.sv
// Directed bench for strategy_switch: N_STRAT=5, GAP_CYCLES=4, DRAIN_TIMEOUT=16.
module tb_strategy_switch;

    logic        clock;
    logic        reset;
    logic [7:0]  sel_req;
    logic        sel_valid;
    logic [79:0] strat_out;
    logic [4:0]  strat_busy;
    logic [4:0]  strat_en;
    logic [15:0] out;
    logic [7:0]  active_sel;
    logic        switching;
    logic        sel_err;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    strategy_switch #(
        .N_STRAT(5), .OUT_W(16), .SEL_W(8), .GAP_CYCLES(4),
        .DRAIN_TIMEOUT(16), .SAFE_VALUE(16'h0000), .RESET_SEL(0)
    ) dut (
        .clock(clock), .reset(reset), .sel_req(sel_req), .sel_valid(sel_valid),
        .strat_out(strat_out), .strat_busy(strat_busy), .strat_en(strat_en),
        .out(out), .active_sel(active_sel), .switching(switching),
        .sel_err(sel_err), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (switching === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        if (cycles >= 200) check("wait_bound", {31'b0, switching}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset      = 1'b0;
        sel_req    = 8'd0;
        sel_valid  = 1'b0;
        strat_busy = 5'b00000;
        strat_out  = {16'h4444, 16'h3333, 16'h2222, 16'hAAAA, 16'h1111};

        #12;
        check("rst_out",   out,         32'h0);
        check("rst_en",    strat_en,    32'b00001);
        check("rst_sel",   active_sel,  32'd0);
        check("rst_sw",    switching,   32'd0);
        check("rst_selerr", sel_err,    32'd0);
        check("rst_to",    timeout_err, 32'd0);

        @(negedge clock);
        reset = 1'b1;
        tick();
        check("out_s0", out, 32'h1111);
        check("en_s0",  strat_en, 32'b00001);

        // 0 -> 2, busy[0] falls so the third DRAIN cycle sees it low
        strat_busy = 5'b00001;
        sel_req = 8'd2; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("sw_start",  switching, 32'd1);
        check("en_drain",  strat_en,  32'd0);
        check("out_drain", out,       32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("sw_hold",  switching, 32'd1);
            check("out_safe", out,       32'h0);
            if (k == 2) strat_busy = 5'b00000;
        end
        tick();
        check("sw_end2",  switching,  32'd0);
        check("sel_2",    active_sel, 32'd2);
        check("en_2",     strat_en,   32'b00100);
        check("out_gap2", out,        32'h0);
        tick();
        check("out_s2",   out,        32'h2222);

        // out-of-range request in ACTIVE
        sel_req = 8'd7; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("selerr_act", sel_err,    32'd1);
        check("sw_err_act", switching,  32'd0);
        check("sel_err_act", active_sel, 32'd2);
        tick();
        check("selerr_clr", sel_err, 32'd0);
        check("out_s2b",    out,     32'h2222);

        // out-of-range request in DRAIN leaves target 3
        strat_busy = 5'b00100;
        sel_req = 8'd3; sel_valid = 1'b1;
        tick();
        check("sw_d3",     switching, 32'd1);
        check("selerr_d0", sel_err,   32'd0);
        sel_req = 8'd7;
        tick();
        sel_valid = 1'b0;
        strat_busy = 5'b00000;
        check("selerr_drn", sel_err,   32'd1);
        check("sw_drn_err", switching, 32'd1);
        wait_done(cyc);
        check("cyc_3",  cyc,        32'd5);
        check("sel_3",  active_sel, 32'd3);
        check("en_3",   strat_en,   32'b01000);
        tick();
        check("out_s3", out, 32'h3333);

        // drain timeout: busy[3] stuck high
        strat_busy = 5'b01000;
        sel_req = 8'd1; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        check("to_pre",   timeout_err, 32'd0);
        check("sw_to",    switching,   32'd1);
        tick();
        check("to_set",   timeout_err, 32'd1);
        wait_done(cyc);
        check("cyc_to",   cyc,         32'd4);
        check("sel_1",    active_sel,  32'd1);
        check("en_1",     strat_en,    32'b00010);
        check("to_stick", timeout_err, 32'd1);
        tick();
        check("out_s1",   out,         32'hAAAA);
        sel_req = 8'd1; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("to_clr",    timeout_err, 32'd0);
        check("same_nosw", switching,   32'd0);
        check("same_sel",  active_sel,  32'd1);
        strat_busy = 5'b00000;

        // retarget during GAP without counter restart
        sel_req = 8'd3; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("sw_h0", switching, 32'd1);
        tick();
        sel_req = 8'd4; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("en_gap", strat_en,  32'd0);
        check("sw_gap", switching, 32'd1);
        wait_done(cyc);
        check("cyc_gap", cyc,        32'd3);
        check("sel_4",   active_sel, 32'd4);
        check("en_4",    strat_en,   32'b10000);
        tick();
        check("out_s4",  out,        32'h4444);

        // async reset in the middle of GAP
        sel_req = 8'd2; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        tick();
        tick();
        check("sw_pre_rst", switching, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_out", out,         32'h0);
        check("arst_en",  strat_en,    32'b00001);
        check("arst_sel", active_sel,  32'd0);
        check("arst_sw",  switching,   32'd0);
        check("arst_to",  timeout_err, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("post_out", out,        32'h1111);
        check("post_sel", active_sel, 32'd0);
        tick();
        tick();
        check("post_sw",  switching,  32'd0);
        check("post_en",  strat_en,   32'b00001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
